// File: rtl/display_frame_scheduler_pkg.sv
// Shared types and constants for the serial display frame scheduler.
// The frame length helper keeps the sub-module and the top in agreement.
package display_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_DONE
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DEFAULT_BLANK_CODE = 4'hF;

  function automatic int frame_bits(input int num_digits);
    return DIGIT_W * num_digits;
  endfunction

endpackage

// File: rtl/display_frame_scheduler_shift_reg.sv
// Frame shift register: parallel load, MSB-first left shift, bit counter.
// last_bit flags the shift that completes the frame.
module frame_shift_reg
  import display_frame_scheduler_pkg::*;
#(
  parameter int WIDTH = frame_bits(6),
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_word,
  output logic             msb,
  output logic             last_bit
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] word_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      word_q  <= load_word;
      count_q <= '0;
    end else if (shift) begin
      word_q  <= {word_q[WIDTH-2:0], 1'b0};
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Zeros shift in, so the line idles low once the frame has been sent.
  assign msb      = word_q[WIDTH-1];
  assign last_bit = (count_q == LAST_COUNT);

endmodule

// File: rtl/display_frame_scheduler.sv
// Request-driven display frame sequencer: loads six BCD digits, shifts them
// out MSB-first on serial_out/clk_out, then strobes latch_out.
module display_frame_scheduler
  import display_frame_scheduler_pkg::*;
#(
  parameter int                 NUM_DIGITS = 6,
  parameter int                 HALF_PER   = 2,
  parameter logic [DIGIT_W-1:0] BLANK_CODE = DEFAULT_BLANK_CODE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          refresh_req,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  input  logic                          blank,
  input  logic                          suppress_lz,
  output logic                          busy,
  output logic                          done,
  output logic                          serial_out,
  output logic                          clk_out,
  output logic                          latch_out
);

  localparam int NBITS = frame_bits(NUM_DIGITS);
  localparam int PH_W  = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PER - 1);

  state_t          state_q, next_state;
  logic [PH_W-1:0] phase_q;
  logic            pending_q;
  logic [1:0]      rst_sync_q;
  logic            rst_int_n;
  logic            phase_last, timed, last_bit;
  logic            busy_d, done_d, clk_d, latch_d;
  logic [NBITS-1:0] load_word;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign timed      = state_q inside {S_SHIFT_LO, S_SHIFT_HI, S_LATCH};
  assign phase_last = (phase_q == PH_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    load_word = digits;
    if (blank) begin
      load_word = {NUM_DIGITS{BLANK_CODE}};
    end else if (suppress_lz && digits[NBITS-1 -: DIGIT_W] == '0) begin
      load_word[NBITS-1 -: DIGIT_W] = BLANK_CODE;
    end
  end

  frame_shift_reg #(.WIDTH(NBITS)) u_shift (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .load      (state_q == S_LOAD),
    .shift     (state_q == S_SHIFT_HI && phase_last),
    .load_word (load_word),
    .msb       (serial_out),
    .last_bit  (last_bit)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_q <= S_IDLE;
    else            state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      S_IDLE:     if (refresh_req || pending_q) next_state = S_LOAD;
      S_LOAD:     next_state = S_SHIFT_LO;
      S_SHIFT_LO: if (phase_last) next_state = S_SHIFT_HI;
      S_SHIFT_HI: if (phase_last) next_state = last_bit ? S_LATCH : S_SHIFT_LO;
      S_LATCH:    if (phase_last) next_state = S_DONE;
      S_DONE:     next_state = (refresh_req || pending_q) ? S_LOAD : S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the state.
  always_comb begin
    busy_d  = (next_state != S_IDLE);
    done_d  = (next_state == S_DONE);
    clk_d   = (next_state == S_SHIFT_HI);
    latch_d = (next_state == S_LATCH);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      clk_out   <= 1'b0;
      latch_out <= 1'b0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      clk_out   <= clk_d;
      latch_out <= latch_d;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      phase_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (next_state != state_q) phase_q <= '0;
      else if (timed)            phase_q <= phase_q + PH_W'(1);
      // Requests that arrive while a frame runs collapse into one pending flag.
      if (next_state == S_LOAD) pending_q <= 1'b0;
      else if (refresh_req)     pending_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_frame_scheduler.sv
// Scoreboard bench: a time-based request model predicts frames for two
// instances (HALF_PER 2 and 1); per-instance monitors reassemble and compare.
module tb_display_frame_scheduler;

  typedef struct packed {
    logic [23:0] word;
    logic        b2b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [23:0] digits;
  logic        blank, slz;
  logic [1:0]  busy, done, ser, sclk, latch;

  int vectors = 0;
  int miscompares = 0;
  int stray[2];
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;

  display_frame_scheduler #(.NUM_DIGITS(6), .HALF_PER(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .refresh_req(req[0]), .digits(digits), .blank(blank),
    .suppress_lz(slz), .busy(busy[0]), .done(done[0]), .serial_out(ser[0]),
    .clk_out(sclk[0]), .latch_out(latch[0]));

  display_frame_scheduler #(.NUM_DIGITS(6), .HALF_PER(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .refresh_req(req[1]), .digits(digits), .blank(blank),
    .suppress_lz(slz), .busy(busy[1]), .done(done[1]), .serial_out(ser[1]),
    .clk_out(sclk[1]), .latch_out(latch[1]));

  function automatic int hp(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int flen(input int k);
    return 1 + 2 * hp(k) * 24 + hp(k) + 1;
  endfunction

  function automatic logic [23:0] frame_word(input logic [23:0] d, input logic b, input logic s);
    logic [23:0] w;
    w = d;
    if (b) w = 24'hFFFFFF;
    else if (s && d[23:20] == 4'h0) w[23:20] = 4'hF;
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request while idle opens a frame of flen cycles; requests
  // during the frame (DONE included) coalesce into one follow-on frame.
  initial begin : model
    bit          act[2], pend[2], b2b[2];
    int unsigned load_at[2], done_at[2];
    int unsigned cyc;
    exp_t        e;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          act[k] = 0; pend[k] = 0;
        end else if (!act[k]) begin
          if (req[k]) begin
            act[k] = 1; b2b[k] = 0;
            load_at[k] = cyc + 1; done_at[k] = cyc + flen(k);
          end
        end else begin
          if (req[k]) pend[k] = 1;
          if (cyc == load_at[k]) begin
            e.word = frame_word(digits, blank, slz);
            e.b2b  = b2b[k];
            if (k == 0) q0.push_back(e); else q1.push_back(e);
          end
          if (cyc == done_at[k]) begin
            if (pend[k]) begin
              pend[k] = 0; b2b[k] = 1;
              load_at[k] = cyc + 1; done_at[k] = cyc + flen(k);
            end else begin
              act[k] = 0;
            end
          end
        end
      end
    end
  end

  task automatic monitor(input int k);
    bit          in_fr, prev_done, prev_clk, prev_ser, b2b;
    int          n, rises, first_rise, lat, viol, sz;
    logic [23:0] word;
    exp_t        e;
    in_fr = 0; prev_done = 0; prev_clk = 0; prev_ser = 0;
    n = 0; rises = 0; first_rise = -1; lat = 0; viol = 0; word = '0; b2b = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_fr = 0; prev_done = 0; prev_clk = 0; prev_ser = 0;
        continue;
      end
      if (!busy[k] && (done[k] | sclk[k] | latch[k] | ser[k])) stray[k]++;
      if (busy[k] && !in_fr) begin
        in_fr = 1; b2b = prev_done; n = 0; rises = 0; first_rise = -1;
        lat = 0; viol = 0; word = '0;
      end
      if (in_fr) begin
        if (sclk[k] && !prev_clk) begin
          rises++;
          word = {word[22:0], ser[k]};
          if (first_rise < 0) first_rise = n;
          if (ser[k] !== prev_ser) viol++;
        end else if (sclk[k] && ser[k] !== prev_ser) begin
          viol++;
        end
        if (latch[k]) begin
          lat++;
          if (sclk[k]) viol++;
        end
        if (done[k]) begin
          sz = (k == 0) ? q0.size() : q1.size();
          check($sformatf("d%0d_frame_expected", k), 32'(sz != 0), 32'd1);
          check($sformatf("d%0d_length", k), n, flen(k) - 1);
          check($sformatf("d%0d_rises", k), rises, 24);
          check($sformatf("d%0d_first_rise", k), first_rise, 1 + hp(k));
          check($sformatf("d%0d_latch_cycles", k), lat, hp(k));
          check($sformatf("d%0d_timing_violations", k), viol, 0);
          if (sz != 0) begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("d%0d_word", k), 32'(word), 32'(e.word));
            check($sformatf("d%0d_back_to_back", k), 32'(b2b), 32'(e.b2b));
          end
          in_fr = 0;
        end
        n++;
      end
      prev_done = done[k]; prev_clk = sclk[k]; prev_ser = ser[k];
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input int k);
    @(negedge clk);
    req[k] = 1'b1;
    @(negedge clk);
    req[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[k] && n < 500);
    check($sformatf("d%0d_idle_reached", k), 32'(busy[k]), 32'd0);
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[k] && n < 300);
    check($sformatf("d%0d_done_seen", k), 32'(done[k]), 32'd1);
  endtask

  initial begin
    stray[0] = 0; stray[1] = 0;
    rst_n = 1'b0; req = '0; digits = '0; blank = 1'b0; slz = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_outputs_d0", 32'({busy[0], done[0], ser[0], sclk[0], latch[0]}), 32'd0);
    check("reset_outputs_d1", 32'({busy[1], done[1], ser[1], sclk[1], latch[1]}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frame, leading-zero suppression on/off, blanking.
    digits = 24'h123456; pulse(0); wait_idle(0);
    digits = 24'h012345; slz = 1'b1; pulse(0); wait_idle(0);
    slz = 1'b0; pulse(0); wait_idle(0);
    digits = 24'h987654; blank = 1'b1; pulse(0); wait_idle(0);
    blank = 1'b0;

    // Three requests during one frame coalesce into a single follow-on frame.
    digits = 24'h222222; pulse(0);
    repeat (10) @(negedge clk); pulse(0);
    repeat (20) @(negedge clk); pulse(0);
    repeat (20) @(negedge clk); pulse(0);
    digits = 24'h111111;
    wait_idle(0);

    // Request landing exactly in the DONE cycle.
    digits = 24'h345678; pulse(0); wait_done(0);
    req[0] = 1'b1; digits = 24'h876543;
    @(negedge clk); req[0] = 1'b0;
    wait_idle(0);

    // Reset after bit 10 of a frame.
    digits = 24'hABCDEF; pulse(0);
    repeat (1 + 2 * 2 * 10 + 2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs_d0", 32'({busy[0], done[0], ser[0], sclk[0], latch[0]}), 32'd0);
    q0.delete(); q1.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_idle_d0", 32'({busy[0], latch[0]}), 32'd0);
    digits = 24'h560719; slz = 1'b1; pulse(0); wait_idle(0);
    slz = 1'b0;

    // HALF_PER = 1 instance.
    digits = 24'h123456; pulse(1); wait_idle(1);
    digits = 24'h000001; slz = 1'b1; pulse(1); wait_idle(1);

    // Randomised frames with mid-frame digit changes and extra requests.
    for (int i = 0; i < 14; i++) begin
      int k;
      k = (i % 3 == 2) ? 1 : 0;
      digits = 24'($urandom);
      if ($urandom_range(2) == 0) digits[23:20] = 4'h0;
      blank = ($urandom_range(3) == 0);
      slz   = 1'($urandom_range(1));
      pulse(k);
      digits = 24'($urandom);
      if ($urandom_range(1) == 1) begin
        repeat ($urandom_range(60, 5)) @(negedge clk);
        digits = 24'($urandom);
        pulse(k);
      end
      wait_idle(k);
      repeat ($urandom_range(3)) @(negedge clk);
    end

    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);
    check("frames_outstanding_d0", q0.size(), 0);
    check("frames_outstanding_d1", q1.size(), 0);
    check("idle_quiet_d0", stray[0], 0);
    check("idle_quiet_d1", stray[1], 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_frame_scheduler.md
Name: display_frame_scheduler

Overview:
- Sequences the serial display output datapath. On each refresh request it captures the six BCD time digits, shifts them out MSB-first on a serial data/clock pair, then pulses the latch line.
- Sits between the time register (digit source) and the external shift-register/decoder chain.
- Replaces free-running shift clocking with request-driven frames that carry a busy/done handshake.

Parameters:
- NUM_DIGITS, 6, number of 4-bit digits per frame; frame length = 4*NUM_DIGITS bits.
- HALF_PER, 2, system clocks per serial-clock half period; legal range ≥1.
- BLANK_CODE, 4'hF, digit code the downstream decoder treats as blank.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- refresh_req  in  1  single-cycle request to send one frame.
- digits  in  4*NUM_DIGITS  packed digits, hours_msd in the MSBs down to seconds_lsd in the LSBs.
- blank  in  1  when high at capture, every digit is sent as BLANK_CODE.
- suppress_lz  in  1  when high at capture and the top digit is 0, the top digit is sent as BLANK_CODE.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse at frame completion.
- serial_out  out  1  serial data.
- clk_out  out  1  serial shift clock; downstream samples on the rising edge.
- latch_out  out  1  parallel-load strobe, active high.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE, pending = 0, shift register = 0, bit counter = 0, phase counter = 0.
  - All outputs 0: busy, done, serial_out, clk_out, latch_out.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE:
  - If refresh_req or pending is high, go to LOAD next cycle and clear pending.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - Capture the frame from digits, blank and suppress_lz as sampled in this cycle. The latest digit value wins.
  - Apply blanking, then leading-zero suppression, to form the 4*NUM_DIGITS-bit shift word.
  - busy rises in this cycle and stays high through DONE inclusive.
- SHIFT_LO (HALF_PER cycles):
  - clk_out = 0.
  - serial_out = shift word MSB, stable for the whole state.
  - Then go to SHIFT_HI.
- SHIFT_HI (HALF_PER cycles):
  - clk_out = 1; serial_out unchanged.
  - On exit, shift the word left by one and increment the bit counter.
  - If the counter reaches 4*NUM_DIGITS, go to LATCH; otherwise go to SHIFT_LO.
- LATCH (HALF_PER cycles): latch_out = 1, clk_out = 0, serial_out = 0.
- DONE (1 cycle):
  - done = 1, busy = 1.
  - Next cycle: go to LOAD if pending, else IDLE.
- Frame timing:
  - Frame length = 1 + 2*HALF_PER*4*NUM_DIGITS + HALF_PER + 1 cycles. Default is 1 + 96 + 2 + 1 = 100.
  - Request in IDLE at cycle t: LOAD at t+1, first data bit visible at t+2, first clk_out rise at t+2+HALF_PER.
- refresh_req arriving while busy (LOAD through DONE):
  - Sets pending. Any number of requests coalesce into one.
  - A request in the DONE cycle also sets pending, and the next frame starts at DONE+1 with no IDLE cycle.
- Timing constraints on outputs:
  - clk_out never pulses during LATCH.
  - latch_out never overlaps clk_out high.
  - All outputs are registered, so there are no combinational paths from inputs.
- Reset asserted mid-frame:
  - All outputs drop to 0 immediately and pending is lost.
  - No partial latch pulse is generated.
- Counters:
  - Bit counter width = clog2(4*NUM_DIGITS + 1).
  - Phase counter width = clog2(HALF_PER) (min 1); it wraps to 0 on every state change.

Decomposition:
- Shared package:
  - state enum.
  - BLANK_CODE.
  - Digit width constant 4.
  - Function for the frame bit count.
- One natural sub-module: frame_shift_reg. It holds the parallel load, left shift, and MSB out, plus the bit counter and its terminal flag. The FSM and phase counter stay in the top.

Test Plan:
- Basic frame:
  - Stimulus: reset, then one refresh_req with digits=24'h123456, blank=0, suppress_lz=0.
  - Required: 24 clk_out rises; bits sampled on the rises = 0001_0010_0011_0100_0101_0110.
  - Required: latch_out high for 2 cycles; done exactly 99 cycles after the LOAD cycle; busy high for exactly 100 cycles.
- Leading-zero suppression:
  - Stimulus: digits=24'h012345 with suppress_lz=1.
  - Required: first nibble shifted = 4'hF, rest 1,2,3,4,5.
  - Repeat with suppress_lz=0: first nibble = 4'h0.
- Blank:
  - Stimulus: blank=1, digits=24'h987654.
  - Required: shifted word = 24'hFFFFFF.
- Coalesced request:
  - Stimulus: three refresh_req pulses during one frame; digits changed to 24'h111111 before the second LOAD.
  - Required: exactly two frames total, and the second frame carries 24'h111111.
  - Required: DONE is followed directly by LOAD.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after bit 10 of a frame.
  - Required: all outputs 0 in the same cycle; after release the block idles with no latch pulse.
  - Required: a fresh request then produces a correct full frame.
- Parameter sweep:
  - Stimulus: HALF_PER=1.
  - Required: frame length 1 + 48 + 1 + 1 = 51 cycles; clk_out alternates every cycle; data stable across each rising edge.
